// File: rtl/control_seq.sv
// Multi-cycle CPU control sequencer: FETCH/EXEC with memory and ALU wait states,
// a hardware call stack for CALL/RET, and a HALT state.
module control_seq #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [16+DATA_W-1:0] insn,
    input  logic                 insn_valid,
    output logic [ADDR_W-1:0]    pc,
    output logic [2:0]           operand1,
    output logic [2:0]           operand2,
    output logic [2:0]           results,
    output logic [6:0]           alu_op,
    output logic [3:0]           alu_params,
    output logic                 alu_imm,
    output logic                 alu_start,
    input  logic                 alu_busy,
    input  logic [5:0]           alu_status,
    output logic [DATA_W-1:0]    imm,
    input  logic [ADDR_W-1:0]    hreg,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rom,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic                 mem_ack,
    output logic                 stack_err,
    output logic                 halted
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [4:0] OPC_LDR  = 5'h01;
    localparam logic [4:0] OPC_STR  = 5'h02;
    localparam logic [4:0] OPC_LPT  = 5'h03;
    localparam logic [4:0] OPC_SPT  = 5'h04;
    localparam logic [4:0] OPC_CMP  = 5'h05;
    localparam logic [4:0] OPC_ADD  = 5'h06;
    localparam logic [4:0] OPC_SUB  = 5'h07;
    localparam logic [4:0] OPC_MUL  = 5'h08;
    localparam logic [4:0] OPC_DIV  = 5'h09;
    localparam logic [4:0] OPC_MOD  = 5'h0A;
    localparam logic [4:0] OPC_AND  = 5'h0B;
    localparam logic [4:0] OPC_OR   = 5'h0C;
    localparam logic [4:0] OPC_XOR  = 5'h0D;
    localparam logic [4:0] OPC_NOT  = 5'h0E;
    localparam logic [4:0] OPC_LSL  = 5'h0F;
    localparam logic [4:0] OPC_LSR  = 5'h10;
    localparam logic [4:0] OPC_JMP  = 5'h14;
    localparam logic [4:0] OPC_CALL = 5'h15;
    localparam logic [4:0] OPC_RET  = 5'h16;
    localparam logic [4:0] OPC_JOC  = 5'h17;
    localparam logic [4:0] OPC_HLT  = 5'h1F;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEMWAIT, S_ALUWAIT, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [4:0]        opc_q, opc_d;
    logic              rom_q, rom_d;
    logic [2:0]        op1_q, op1_d, op2_q, op2_d, res_q, res_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [6:0]        alu_op_q, alu_op_d;
    logic [3:0]        alu_params_q, alu_params_d;
    logic              alu_imm_q, alu_imm_d;
    logic              alu_start_q, alu_start_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rom_q, mem_rom_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              stack_err_q, stack_err_d;
    logic              halted_q, halted_d;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic              push_en;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic [ADDR_W-1:0] pc_inc, w2_addr;

    logic [4:0]        in_opc;
    logic [DATA_W-1:0] in_w2;
    logic              dec_alu, dec_aimm;
    logic [6:0]        dec_op;
    logic [3:0]        dec_par;

    assign in_opc   = insn[6:2];
    assign in_w2    = insn[16+DATA_W-1:16];
    assign pc_inc   = pc_q + 1'b1;
    assign w2_addr  = ADDR_W'(imm_q);
    assign push_idx = IDX_W'(sp_q);
    assign pop_idx  = IDX_W'(sp_q - 1'b1);

    // ALU issue fields are decoded straight from insn so they are valid during EXEC.
    always_comb begin
        dec_alu  = 1'b1;
        dec_op   = '0;
        dec_par  = '0;
        dec_aimm = insn[1];
        case (in_opc)
            OPC_CMP: dec_op = 7'b1000010;
            OPC_ADD: dec_op = 7'b1000001;
            OPC_SUB: begin dec_op = 7'b1000001; dec_par = 4'd1; end
            OPC_MUL: dec_op = 7'b1100000;
            OPC_DIV: dec_op = 7'b1100001;
            OPC_MOD: begin dec_op = 7'b1100001; dec_par = 4'd1; end
            OPC_AND: dec_op = 7'b0010000;
            OPC_OR:  begin dec_op = 7'b0010000; dec_par = 4'd1; end
            OPC_XOR: begin dec_op = 7'b0010000; dec_par = 4'd2; end
            OPC_NOT: begin dec_op = 7'b0010000; dec_par = 4'd3; dec_aimm = 1'b0; end
            OPC_LSL: begin dec_op = 7'b0001000; dec_par = in_w2[3:0]; dec_aimm = 1'b1; end
            OPC_LSR: begin dec_op = 7'b0000100; dec_par = in_w2[3:0]; dec_aimm = 1'b1; end
            default: begin dec_alu = 1'b0; dec_aimm = 1'b0; end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        sp_d         = sp_q;
        opc_d        = opc_q;
        rom_d        = rom_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        res_d        = res_q;
        imm_d        = imm_q;
        alu_op_d     = alu_op_q;
        alu_params_d = alu_params_q;
        alu_imm_d    = alu_imm_q;
        alu_start_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_rom_d    = mem_rom_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        stack_err_d  = stack_err_q;
        halted_d     = halted_q;
        push_en      = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (insn_valid) begin
                    state_d      = S_EXEC;
                    opc_d        = in_opc;
                    rom_d        = insn[0];
                    op1_d        = insn[9:7];
                    op2_d        = insn[12:10];
                    res_d        = insn[15:13];
                    imm_d        = in_w2;
                    alu_op_d     = dec_op;
                    alu_params_d = dec_par;
                    alu_imm_d    = dec_aimm;
                    alu_start_d  = dec_alu;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (opc_q)
                    OPC_LDR, OPC_STR, OPC_LPT, OPC_SPT: begin
                        state_d     = S_MEMWAIT;
                        pc_d        = pc_q;
                        mem_addr_d  = (opc_q == OPC_LPT || opc_q == OPC_SPT) ? hreg : w2_addr;
                        mem_rom_d   = rom_q;
                        mem_read_d  = (opc_q == OPC_LDR || opc_q == OPC_LPT);
                        mem_write_d = (opc_q == OPC_STR || opc_q == OPC_SPT);
                    end
                    OPC_DIV, OPC_MOD: begin
                        state_d = S_ALUWAIT;
                        pc_d    = pc_q;
                    end
                    OPC_JMP: pc_d = w2_addr;
                    // The condition mask occupies the op1/op2 fields of the instruction.
                    OPC_JOC: if (|({op2_q, op1_q} & alu_status)) pc_d = w2_addr;
                    OPC_CALL: begin
                        if (sp_q == SP_W'(STACK_DEPTH)) begin
                            stack_err_d = 1'b1;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + 1'b1;
                            pc_d    = w2_addr;
                        end
                    end
                    OPC_RET: begin
                        if (sp_q == '0) begin
                            stack_err_d = 1'b1;
                        end else begin
                            sp_d = sp_q - 1'b1;
                            pc_d = stack_mem[pop_idx];
                        end
                    end
                    OPC_HLT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        pc_d     = pc_q;
                    end
                    default: ;
                endcase
            end
            S_MEMWAIT: begin
                if (mem_ack) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    pc_d        = pc_inc;
                    state_d     = S_FETCH;
                end
            end
            S_ALUWAIT: begin
                if (!alu_busy) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push_en) stack_mem[push_idx] <= pc_inc;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            sp_q         <= '0;
            opc_q        <= '0;
            rom_q        <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            res_q        <= '0;
            imm_q        <= '0;
            alu_op_q     <= '0;
            alu_params_q <= '0;
            alu_imm_q    <= 1'b0;
            alu_start_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_rom_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            stack_err_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            opc_q        <= opc_d;
            rom_q        <= rom_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            res_q        <= res_d;
            imm_q        <= imm_d;
            alu_op_q     <= alu_op_d;
            alu_params_q <= alu_params_d;
            alu_imm_q    <= alu_imm_d;
            alu_start_q  <= alu_start_d;
            mem_addr_q   <= mem_addr_d;
            mem_rom_q    <= mem_rom_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            stack_err_q  <= stack_err_d;
            halted_q     <= halted_d;
        end
    end

    assign pc         = pc_q;
    assign operand1   = op1_q;
    assign operand2   = op2_q;
    assign results    = res_q;
    assign alu_op     = alu_op_q;
    assign alu_params = alu_params_q;
    assign alu_imm    = alu_imm_q;
    assign alu_start  = alu_start_q;
    assign imm        = imm_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rom    = mem_rom_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign stack_err  = stack_err_q;
    assign halted     = halted_q;
endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: an instruction-level reference model predicts each cycle's
// outputs and one negedge process compares them; directed literals pin the model.
module tb_control_seq;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 2;
    localparam int IW     = 16 + DATA_W;

    localparam int OP_NOP = 0,  OP_LDR = 1,  OP_STR = 2,  OP_LPT = 3,  OP_SPT = 4;
    localparam int OP_CMP = 5,  OP_ADD = 6,  OP_SUB = 7,  OP_MUL = 8,  OP_DIV = 9;
    localparam int OP_MOD = 10, OP_AND = 11, OP_OR = 12,  OP_XOR = 13, OP_NOT = 14;
    localparam int OP_LSL = 15, OP_LSR = 16, OP_JMP = 20, OP_CALL = 21, OP_RET = 22;
    localparam int OP_JOC = 23, OP_HLT = 31;

    logic              CLK = 1'b0;
    logic              RST;
    logic [IW-1:0]     insn;
    logic              insn_valid;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        operand1, operand2, results;
    logic [6:0]        alu_op;
    logic [3:0]        alu_params;
    logic              alu_imm, alu_start, alu_busy;
    logic [5:0]        alu_status;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] hreg, mem_addr;
    logic              mem_rom, mem_read, mem_write, mem_ack, stack_err, halted;

    control_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_PC('0)) dut (
        .CLK(CLK), .RST(RST), .insn(insn), .insn_valid(insn_valid), .pc(pc),
        .operand1(operand1), .operand2(operand2), .results(results),
        .alu_op(alu_op), .alu_params(alu_params), .alu_imm(alu_imm), .alu_start(alu_start),
        .alu_busy(alu_busy), .alu_status(alu_status), .imm(imm), .hreg(hreg),
        .mem_addr(mem_addr), .mem_rom(mem_rom), .mem_read(mem_read), .mem_write(mem_write),
        .mem_ack(mem_ack), .stack_err(stack_err), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Expected image of the outputs for the current cycle
    logic              exp_valid = 1'b0;
    logic              exp_sel_chk, exp_alu_chk, exp_mem_chk;
    logic [ADDR_W-1:0] exp_pc, exp_mem_addr;
    logic              exp_read, exp_write, exp_start, exp_halted, exp_err, exp_rom, exp_aimm;
    logic [6:0]        exp_op;
    logic [3:0]        exp_par;
    logic [DATA_W-1:0] exp_imm;
    logic [2:0]        exp_o1, exp_o2, exp_res;

    // Reference model state
    logic [ADDR_W-1:0] m_pc;
    logic [ADDR_W-1:0] m_stack[$];
    logic              m_err, m_halted;

    int checks = 0;
    int errors = 0;
    int rd_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (mem_read === 1'b1) rd_cycles++;
        if (exp_valid) begin
            chk("pc", 64'(pc), 64'(exp_pc));
            chk("mem_read", 64'(mem_read), 64'(exp_read));
            chk("mem_write", 64'(mem_write), 64'(exp_write));
            chk("alu_start", 64'(alu_start), 64'(exp_start));
            chk("halted", 64'(halted), 64'(exp_halted));
            chk("stack_err", 64'(stack_err), 64'(exp_err));
            if (exp_sel_chk) begin
                chk("operand1", 64'(operand1), 64'(exp_o1));
                chk("operand2", 64'(operand2), 64'(exp_o2));
                chk("results", 64'(results), 64'(exp_res));
                chk("imm", 64'(imm), 64'(exp_imm));
            end
            if (exp_alu_chk) begin
                chk("alu_op", 64'(alu_op), 64'(exp_op));
                chk("alu_params", 64'(alu_params), 64'(exp_par));
                chk("alu_imm", 64'(alu_imm), 64'(exp_aimm));
            end
            if (exp_mem_chk) begin
                chk("mem_addr", 64'(mem_addr), 64'(exp_mem_addr));
                chk("mem_rom", 64'(mem_rom), 64'(exp_rom));
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [IW-1:0] mk(input int opc, input int opv, input int res,
                                          input int o1, input int o2, input int w2);
        logic [IW-1:0] r;
        r          = '0;
        r[1:0]     = opv[1:0];
        r[6:2]     = opc[4:0];
        r[9:7]     = o1[2:0];
        r[12:10]   = o2[2:0];
        r[15:13]   = res[2:0];
        r[IW-1:16] = w2[DATA_W-1:0];
        return r;
    endfunction

    // ALU issue fields each opcode must produce
    task automatic alu_ref(input int opc, input logic [1:0] opv, input logic [DATA_W-1:0] w2,
                           output logic en, output logic [6:0] op, output logic [3:0] par,
                           output logic aimm);
        en = 1'b1; par = 4'd0; aimm = opv[1]; op = 7'd0;
        case (opc)
            OP_CMP: op = 7'b1000010;
            OP_ADD: op = 7'b1000001;
            OP_SUB: begin op = 7'b1000001; par = 4'd1; end
            OP_MUL: op = 7'b1100000;
            OP_DIV: op = 7'b1100001;
            OP_MOD: begin op = 7'b1100001; par = 4'd1; end
            OP_AND: op = 7'b0010000;
            OP_OR:  begin op = 7'b0010000; par = 4'd1; end
            OP_XOR: begin op = 7'b0010000; par = 4'd2; end
            OP_NOT: begin op = 7'b0010000; par = 4'd3; aimm = 1'b0; end
            OP_LSL: begin op = 7'b0001000; par = w2[3:0]; aimm = 1'b1; end
            OP_LSR: begin op = 7'b0000100; par = w2[3:0]; aimm = 1'b1; end
            default: en = 1'b0;
        endcase
    endtask

    task automatic set_base();
        exp_valid = 1'b1; exp_pc = m_pc; exp_read = 1'b0; exp_write = 1'b0; exp_start = 1'b0;
        exp_halted = m_halted; exp_err = m_err;
        exp_sel_chk = 1'b0; exp_alu_chk = 1'b0; exp_mem_chk = 1'b0;
    endtask

    task automatic set_reset_image();
        set_base();
        exp_sel_chk = 1'b1; exp_alu_chk = 1'b1; exp_mem_chk = 1'b1;
        exp_o1 = '0; exp_o2 = '0; exp_res = '0; exp_imm = '0;
        exp_op = '0; exp_par = '0; exp_aimm = 1'b0; exp_mem_addr = '0; exp_rom = 1'b0;
    endtask

    task automatic set_exec_image(input logic [IW-1:0] i);
        logic en, aimm;
        logic [6:0] op;
        logic [3:0] par;
        set_base();
        exp_sel_chk = 1'b1;
        exp_o1 = i[9:7]; exp_o2 = i[12:10]; exp_res = i[15:13]; exp_imm = i[IW-1:16];
        alu_ref(int'(i[6:2]), i[1:0], i[IW-1:16], en, op, par, aimm);
        exp_start = en; exp_alu_chk = en; exp_op = op; exp_par = par; exp_aimm = aimm;
    endtask

    task automatic noise();
        mem_ack    = 1'($urandom_range(0, 1));
        alu_busy   = 1'($urandom_range(0, 1));
        insn_valid = 1'($urandom_range(0, 1));
        insn       = IW'($urandom);
    endtask

    task automatic exec_insn(input logic [IW-1:0] i, input int gap, input int ack_dly,
                             input int busy, input logic [5:0] st, input logic [ADDR_W-1:0] hr);
        int opc;
        logic [ADDR_W-1:0] w2a, nxt;
        opc = int'(i[6:2]);
        w2a = ADDR_W'(i[IW-1:16]);
        nxt = ADDR_W'((int'(m_pc) + 1) % (1 << ADDR_W));
        for (int g = 0; g < gap; g++) begin
            set_base(); noise(); insn_valid = 1'b0; mem_ack = 1'b1; step();
        end
        set_base(); noise(); insn = i; insn_valid = 1'b1; step();
        set_exec_image(i); noise(); alu_status = st; hreg = hr; step();
        if (opc >= OP_LDR && opc <= OP_SPT) begin
            for (int k = 1; k <= ack_dly; k++) begin
                set_base(); noise();
                exp_read     = (opc == OP_LDR || opc == OP_LPT);
                exp_write    = (opc == OP_STR || opc == OP_SPT);
                exp_mem_chk  = 1'b1;
                exp_mem_addr = (opc == OP_LPT || opc == OP_SPT) ? hr : w2a;
                exp_rom      = i[0];
                mem_ack      = (k == ack_dly);
                step();
            end
            m_pc = nxt;
        end else if (opc == OP_DIV || opc == OP_MOD) begin
            for (int k = 0; k <= busy; k++) begin
                set_base(); noise(); alu_busy = (k < busy); step();
            end
            m_pc = nxt;
        end else begin
            case (opc)
                OP_JMP: m_pc = w2a;
                OP_JOC: m_pc = ((i[12:7] & st) != 6'd0) ? w2a : nxt;
                OP_CALL: begin
                    if (m_stack.size() >= DEPTH) begin m_err = 1'b1; m_pc = nxt; end
                    else begin m_stack.push_back(nxt); m_pc = w2a; end
                end
                OP_RET: begin
                    if (m_stack.size() == 0) begin m_err = 1'b1; m_pc = nxt; end
                    else m_pc = m_stack.pop_back();
                end
                OP_HLT: m_halted = 1'b1;
                default: m_pc = nxt;
            endcase
        end
    endtask

    function automatic logic [IW-1:0] rnd_insn();
        return mk($urandom_range(0, 30), $urandom_range(0, 3), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
    endfunction

    initial begin
        int rd0;
        logic [IW-1:0] si;
        RST = 1'b1; insn_valid = 1'b1; insn = '0; mem_ack = 1'b0; alu_busy = 1'b0;
        alu_status = '0; hreg = '0;
        m_pc = '0; m_err = 1'b0; m_halted = 1'b0;
        step();
        set_reset_image(); step();
        set_reset_image(); RST = 1'b0;
        chk("lit_reset_pc", 64'(pc), 64'h0);
        chk("lit_reset_halted", 64'(halted), 64'h0);

        exec_insn(mk(OP_ADD, 2, 3, 1, 0, 'h42), 0, 1, 0, 6'd0, '0);
        chk("lit_add_pc", 64'(pc), 64'h1);

        rd0 = rd_cycles;
        exec_insn(mk(OP_LDR, 1, 2, 0, 0, 'h400), 1, 3, 0, 6'd0, '0);
        chk("lit_ldr_read_cycles", 64'(rd_cycles - rd0), 64'd3);
        chk("lit_ldr_pc", 64'(pc), 64'h2);

        exec_insn(mk(OP_JMP, 0, 0, 0, 0, 5), 0, 1, 0, 6'd0, '0);
        exec_insn(mk(OP_CALL, 0, 0, 0, 0, 'h10), 0, 1, 0, 6'd0, '0);
        exec_insn(mk(OP_CALL, 0, 0, 0, 0, 'h20), 0, 1, 0, 6'd0, '0);
        exec_insn(mk(OP_CALL, 0, 0, 0, 0, 'h30), 0, 1, 0, 6'd0, '0);
        chk("lit_call_ovf_pc", 64'(pc), 64'h21);
        chk("lit_call_ovf_err", 64'(stack_err), 64'h1);
        exec_insn(mk(OP_RET, 0, 0, 0, 0, 0), 0, 1, 0, 6'd0, '0);
        chk("lit_ret1_pc", 64'(pc), 64'h11);
        exec_insn(mk(OP_RET, 0, 0, 0, 0, 0), 0, 1, 0, 6'd0, '0);
        chk("lit_ret2_pc", 64'(pc), 64'h6);
        exec_insn(mk(OP_RET, 0, 0, 0, 0, 0), 0, 1, 0, 6'd0, '0);
        chk("lit_ret_unf_pc", 64'(pc), 64'h7);
        chk("lit_ret_unf_err", 64'(stack_err), 64'h1);

        exec_insn(mk(OP_JOC, 0, 0, 1, 0, 'h100), 0, 1, 0, 6'b000001, '0);
        chk("lit_joc_taken", 64'(pc), 64'h100);
        exec_insn(mk(OP_JOC, 0, 0, 1, 0, 'h200), 0, 1, 0, 6'b000010, '0);
        chk("lit_joc_not_taken", 64'(pc), 64'h101);
        exec_insn(mk(OP_DIV, 0, 1, 2, 3, 0), 0, 1, 5, 6'd0, '0);
        chk("lit_div_pc", 64'(pc), 64'h102);

        for (int n = 0; n < 300; n++)
            exec_insn(rnd_insn(), $urandom_range(0, 2), $urandom_range(1, 4),
                      $urandom_range(0, 4), 6'($urandom), ADDR_W'($urandom));

        while (m_stack.size() > 0) exec_insn(mk(OP_RET, 0, 0, 0, 0, 0), 0, 1, 0, 6'd0, '0);
        exec_insn(mk(OP_JMP, 0, 0, 0, 0, 'hFFFF), 0, 1, 0, 6'd0, '0);
        exec_insn(mk(OP_NOP, 0, 0, 0, 0, 0), 0, 1, 0, 6'd0, '0);
        chk("lit_wrap_nop", 64'(pc), 64'h0);
        exec_insn(mk(OP_JMP, 0, 0, 0, 0, 'hFFFF), 0, 1, 0, 6'd0, '0);
        exec_insn(mk(OP_CALL, 0, 0, 0, 0, 'h30), 0, 1, 0, 6'd0, '0);
        exec_insn(mk(OP_RET, 0, 0, 0, 0, 0), 0, 1, 0, 6'd0, '0);
        chk("lit_wrap_call_ret", 64'(pc), 64'h0);

        // Reset arrives during a store's wait state
        exec_insn(mk(OP_CALL, 0, 0, 0, 0, 'h40), 0, 1, 0, 6'd0, '0);
        si = mk(OP_STR, 0, 0, 2, 0, 'h1234);
        set_base(); noise(); insn = si; insn_valid = 1'b1; step();
        set_exec_image(si); noise(); step();
        for (int k = 0; k < 2; k++) begin
            set_base(); noise(); mem_ack = 1'b0;
            exp_write = 1'b1; exp_mem_chk = 1'b1; exp_mem_addr = 16'h1234; exp_rom = 1'b0;
            if (k == 1) RST = 1'b1;
            step();
        end
        RST = 1'b0; m_pc = '0; m_stack.delete(); m_err = 1'b0;
        chk("lit_rst_mem_write", 64'(mem_write), 64'h0);
        chk("lit_rst_pc", 64'(pc), 64'h0);
        chk("lit_rst_err", 64'(stack_err), 64'h0);
        set_reset_image(); noise(); insn_valid = 1'b0; step();
        exec_insn(mk(OP_RET, 0, 0, 0, 0, 0), 0, 1, 0, 6'd0, '0);
        chk("lit_rst_sp_empty_err", 64'(stack_err), 64'h1);
        chk("lit_rst_ret_pc", 64'(pc), 64'h1);

        exec_insn(mk(OP_HLT, 0, 0, 0, 0, 0), 0, 1, 0, 6'd0, '0);
        for (int k = 0; k < 20; k++) begin
            set_base(); noise(); step();
        end
        chk("lit_halt_pc", 64'(pc), 64'h1);
        chk("lit_halt_flag", 64'(halted), 64'h1);

        exp_valid = 1'b0;
        @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Parametrised, multi-cycle successor to the CPU control decoder.
- Replaces the free-running fetch with a FETCH/EXEC/wait sequencer.
- Adds wait-state memory handshake (RAM and ROM data space), multi-cycle ALU ops (DIV/MOD), a hardware call stack (CALL/RET) and HLT.
- Sits between instruction ROM, data memory bus and ALU; drives PC, ALU selects and memory strobes.

Parameters:
- DATA_W, 16, immediate/word2 width; instruction width is 16+DATA_W.
- ADDR_W, 16, PC, memory address and hreg width.
- STACK_DEPTH, 8, call-stack entries (≥1).
- RESET_PC, 0, PC value after reset.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous reset, active-high.
- insn  in  16+DATA_W  instruction: opvar[1:0], opcode[6:2], op1[9:7], op2[12:10], res[15:13], cond[12:7], word2[16+DATA_W-1:16].
- insn_valid  in  1  insn corresponds to current pc.
- pc  out  ADDR_W  instruction address.
- operand1, operand2, results  out  3 each  register selects.
- alu_op  out  7  ALU operation code (same encodings as current ALU).
- alu_params  out  4  ALU sub-op / shift amount.
- alu_imm  out  1  ALU takes imm instead of operand2.
- alu_start  out  1  one-cycle ALU issue pulse.
- alu_busy  in  1  multi-cycle ALU op in progress.
- alu_status  in  6  ALU flags.
- imm  out  DATA_W  word2 latched.
- hreg  in  ADDR_W  pointer register for LPT/SPT.
- mem_addr  out  ADDR_W  data address.
- mem_rom  out  1  access targets ROM data space (opvar[0]).
- mem_read, mem_write  out  1 each  bus strobes.
- mem_ack  in  1  access complete.
- stack_err  out  1  sticky stack overflow/underflow.
- halted  out  1  HLT executed.

Behaviour:
- All outputs registered. Reset values:
  - pc=RESET_PC, sp=0, state=FETCH.
  - All other outputs 0: strobes, alu_start, alu_op, alu_params, selects, imm, mem_addr, mem_rom, stack_err, halted.
- RST in any state, including MEMWAIT and ALUWAIT, aborts the operation on the next edge. Strobes drop and the stack empties.
- FETCH: hold until insn_valid=1, then latch insn into IR and go to EXEC. Minimum instruction time is 2 cycles.
- EXEC (one cycle), by opcode:
  - 0x00 NOP and undefined opcodes: pc+1, go to FETCH.
  - 0x01 LDR / 0x02 STR: mem_addr=word2[ADDR_W-1:0], mem_rom=opvar[0]; results/operand1 latched; go to MEMWAIT.
  - 0x03 LPT / 0x04 SPT: same as LDR/STR but mem_addr=hreg.
  - MEMWAIT: mem_read (load) or mem_write (store) is high for the whole state. Exit on the first cycle mem_ack=1; strobe drops on that edge, pc+1, go to FETCH. mem_ack outside MEMWAIT is ignored.
  - Single-cycle ALU ops (0x05 CMP, 0x06 ADD, 0x07 SUB, 0x08 MUL, 0x0B AND, 0x0C OR, 0x0D XOR, 0x0E NOT, 0x0F LSL, 0x10 LSR): drive selects, alu_op/alu_params per current encodings, alu_imm=opvar[1] (0 for NOT; 1 for LSL/LSR with alu_params=word2[3:0]). alu_start pulses 1 cycle; pc+1, go to FETCH.
  - 0x09 DIV / 0x0A MOD: alu_op=7'b1100001, alu_params=0 (DIV) or 1 (MOD); alu_start pulse; go to ALUWAIT. From the following cycle, wait until alu_busy=0 is sampled, then pc+1, go to FETCH. alu_busy=0 on the first ALUWAIT cycle means 1 wait cycle.
  - 0x14 JMP: pc=word2.
  - 0x17 JOC: pc=word2 if (cond & alu_status)!=0, else pc+1. alu_status is sampled in EXEC.
  - 0x15 CALL: if sp==STACK_DEPTH, set stack_err, pc+1, no push. Otherwise push pc+1, sp+1, pc=word2.
  - 0x16 RET: if sp==0, set stack_err, pc+1. Otherwise pop into pc, sp-1.
  - 0x1F HLT: go to HALT, halted=1. Stay there until RST; insn_valid is ignored.
- pc arithmetic is modulo 2^ADDR_W: 0xFFFF+1 gives 0x0000. A CALL at pc=max pushes 0.
- stack_err is sticky until RST. The stack stays usable after an error.
- alu_start never overlaps mem_read/mem_write.

Test Plan:
- Reset: hold RST for 2 cycles with insn_valid=1 → pc=0, all strobes 0, halted=0. First FETCH occurs the cycle after RST falls.
- ADD immediate: opvar=2'b10, res=3, op1=1, word2=0x0042 → in EXEC alu_op=7'b1000001, alu_params[0]=0, alu_imm=1, imm=0x0042, alu_start for 1 cycle, pc 0→1 after 2 cycles.
- LDR ROM with 3-cycle ack delay: word2=0x0400, opvar=01 → mem_rom=1, mem_addr=0x0400, mem_read high exactly 3 cycles, pc increments once. An early mem_ack in FETCH is ignored.
- CALL/RET with STACK_DEPTH=2:
  - CALL 0x10 from pc=5, then CALL 0x20 → stack {6,0x11}.
  - A third CALL → stack_err=1, pc=0x21.
  - RET, RET → pc=0x11, then 6.
  - A third RET keeps stack_err=1, pc+1.
- JOC plus DIV:
  - cond=6'b000001 with alu_status=6'b000001 → pc=word2.
  - cond=6'b000001 with alu_status=6'b000010 → pc+1.
  - DIV with alu_busy high for 5 cycles → stays in ALUWAIT, pc unchanged until alu_busy falls.
- Reset mid-operation: assert RST during MEMWAIT with mem_write=1 → mem_write=0 and pc=RESET_PC on the next edge, sp=0, stack_err cleared. HLT then → halted=1 and pc frozen for 20 cycles.
